// File: rtl/ysyx_220066_regfile_sb_if.sv
// Bundles the decode/issue side of the register file: the writeback port,
// the pipeline bypass sources, the long-latency unit issue/done ports, flush,
// the read addresses and the operand results.
//   master : issue/pipeline side, drives writes, bypasses, LU events and rs
//   slave  : register file, returns src, rs_valid and busy_any
interface ysyx_220066_regfile_sb_if #(
   parameter int XLEN = 64,
   parameter int AW   = 5,
   parameter int NRD  = 2,
   parameter int NBYP = 2,
   parameter int NLU  = 2
);
   logic                 wb_wen;
   logic [AW-1:0]        wb_rd;
   logic [XLEN-1:0]      wb_data;
   logic [NBYP-1:0]      byp_wen;
   logic [NBYP-1:0]      byp_valid;
   logic [NBYP*AW-1:0]   byp_rd;
   logic [NBYP*XLEN-1:0] byp_data;
   logic [NLU-1:0]       lu_issue;
   logic [NLU*AW-1:0]    lu_issue_rd;
   logic [NLU-1:0]       lu_done;
   logic [NLU*AW-1:0]    lu_done_rd;
   logic [NLU*XLEN-1:0]  lu_result;
   logic                 flush;
   logic [NRD*AW-1:0]    rs;
   logic [NRD*XLEN-1:0]  src;
   logic [NRD-1:0]       rs_valid;
   logic                 busy_any;

   modport master (
      output wb_wen, wb_rd, wb_data, byp_wen, byp_valid, byp_rd, byp_data,
             lu_issue, lu_issue_rd, lu_done, lu_done_rd, lu_result, flush, rs,
      input  src, rs_valid, busy_any
   );

   modport slave (
      input  wb_wen, wb_rd, wb_data, byp_wen, byp_valid, byp_rd, byp_data,
             lu_issue, lu_issue_rd, lu_done, lu_done_rd, lu_result, flush, rs,
      output src, rs_valid, busy_any
   );
endinterface

// File: rtl/ysyx_220066_regfile_sb.sv
// Integer register file with a long-latency scoreboard and operand bypass.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-low reset
//   bus      : ysyx_220066_regfile_sb_if.slave (writes, bypasses, LU events,
//              read addresses in; src / rs_valid / busy_any out)
// Optional (macro YSYX_220066_REGDUMP_EN):
//   dbg_addr : difftest register address
//   dbg_data : raw array contents at dbg_addr (no bypass), 0 for x0
// Each read port resolves, in priority order: x0 / out-of-range, youngest
// matching bypass, same-cycle completion of the owning LU, busy stall,
// same-cycle writeback, array.
module ysyx_220066_regfile_sb #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int NRD  = 2,
   parameter int NBYP = 2,
   parameter int NLU  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_220066_regfile_sb_if.slave bus
`ifdef YSYX_220066_REGDUMP_EN
   ,
   input  logic [AW-1:0]        dbg_addr,
   output logic [XLEN-1:0]      dbg_data
`endif
);

   localparam int          OW     = (NLU > 1) ? $clog2(NLU) : 1;
   localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

   logic [XLEN-1:0] regs_q  [NREG];
   logic [XLEN-1:0] regs_d  [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [OW-1:0]   owner_q [NREG];
   logic [OW-1:0]   owner_d [NREG];

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < NREG_A;
   endfunction

   // Array write: LU ports applied highest index first so the lowest index
   // overwrites, then WB last because it is the younger instruction.
   always_comb begin
      regs_d = regs_q;
      for (int j = NLU-1; j >= 0; j--) begin
         if (bus.lu_done[j] && bus.lu_done_rd[j*AW +: AW] != '0 &&
             in_range(bus.lu_done_rd[j*AW +: AW]))
            regs_d[bus.lu_done_rd[j*AW +: AW]] = bus.lu_result[j*XLEN +: XLEN];
      end
      if (bus.wb_wen && bus.wb_rd != '0 && in_range(bus.wb_rd))
         regs_d[bus.wb_rd] = bus.wb_data;
   end

   // Scoreboard: completions release only their own reservation; issues are
   // applied after so a same-cycle issue re-claims the register; flush last.
   always_comb begin
      busy_d  = busy_q;
      owner_d = owner_q;
      for (int j = 0; j < NLU; j++) begin
         if (bus.lu_done[j] && in_range(bus.lu_done_rd[j*AW +: AW]) &&
             owner_q[bus.lu_done_rd[j*AW +: AW]] == OW'(j))
            busy_d[bus.lu_done_rd[j*AW +: AW]] = 1'b0;
      end
      for (int j = NLU-1; j >= 0; j--) begin
         if (bus.lu_issue[j] && bus.lu_issue_rd[j*AW +: AW] != '0 &&
             in_range(bus.lu_issue_rd[j*AW +: AW])) begin
            busy_d[bus.lu_issue_rd[j*AW +: AW]]  = 1'b1;
            owner_d[bus.lu_issue_rd[j*AW +: AW]] = OW'(j);
         end
      end
      if (bus.flush)
         busy_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q  <= '{default: '0};
         busy_q  <= '0;
         owner_q <= '{default: '0};
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         owner_q <= owner_d;
      end
   end

   logic [NRD*XLEN-1:0] src_c;
   logic [NRD-1:0]      vld_c;
   logic [AW-1:0]       a;
   logic                done_k;
   logic                bhit;
   logic [XLEN-1:0]     bdat;
   logic                bvld;

   always_comb begin
      src_c  = '0;
      vld_c  = '0;
      a      = '0;
      done_k = 1'b0;
      bhit   = 1'b0;
      bdat   = '0;
      bvld   = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         a      = bus.rs[k*AW +: AW];
         done_k = 1'b0;
         bhit   = 1'b0;
         bdat   = '0;
         bvld   = 1'b0;
         if (a == '0 || !in_range(a)) begin
            vld_c[k] = 1'b1;
            done_k   = 1'b1;
         end
         // Descending scan so the youngest (lowest index) match is kept.
         for (int i = NBYP-1; i >= 0; i--) begin
            if (bus.byp_wen[i] && bus.byp_rd[i*AW +: AW] == a) begin
               bhit = 1'b1;
               bdat = bus.byp_data[i*XLEN +: XLEN];
               bvld = bus.byp_valid[i];
            end
         end
         if (!done_k && bhit) begin
            src_c[k*XLEN +: XLEN] = bdat;
            vld_c[k]              = bvld;
            done_k                = 1'b1;
         end
         if (!done_k && busy_q[a]) begin
            done_k = 1'b1;
            for (int j = 0; j < NLU; j++) begin
               if (owner_q[a] == OW'(j) && bus.lu_done[j] &&
                   bus.lu_done_rd[j*AW +: AW] == a) begin
                  src_c[k*XLEN +: XLEN] = bus.lu_result[j*XLEN +: XLEN];
                  vld_c[k]              = 1'b1;
               end
            end
         end
         if (!done_k && bus.wb_wen && bus.wb_rd == a) begin
            src_c[k*XLEN +: XLEN] = bus.wb_data;
            vld_c[k]              = 1'b1;
            done_k                = 1'b1;
         end
         if (!done_k) begin
            src_c[k*XLEN +: XLEN] = regs_q[a];
            vld_c[k]              = 1'b1;
         end
      end
      if (!rst) begin
         src_c = '0;
         vld_c = '0;
      end
   end

   assign bus.src      = src_c;
   assign bus.rs_valid = vld_c;
   assign bus.busy_any = rst & (|busy_q);

`ifdef YSYX_220066_REGDUMP_EN
   assign dbg_data = (dbg_addr == '0 || !in_range(dbg_addr)) ? '0 : regs_q[dbg_addr];
`endif

endmodule

// File: tb/tb_ysyx_220066_regfile_sb.sv
module tb_ysyx_220066_regfile_sb;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ysyx_220066_regfile_sb_if #(.XLEN(64), .AW(5), .NRD(2), .NBYP(2), .NLU(2)) b ();

`ifdef YSYX_220066_REGDUMP_EN
   logic [4:0]  dbg_addr = '0;
   logic [63:0] dbg_data;
   ysyx_220066_regfile_sb #(.XLEN(64), .NREG(32), .AW(5), .NRD(2), .NBYP(2), .NLU(2)) dut (
      .clk(clk), .rst(rst), .bus(b), .dbg_addr(dbg_addr), .dbg_data(dbg_data));
`else
   ysyx_220066_regfile_sb #(.XLEN(64), .NREG(32), .AW(5), .NRD(2), .NBYP(2), .NLU(2)) dut (
      .clk(clk), .rst(rst), .bus(b));
`endif

   typedef struct {
      string       name;
      int          kind;   // 0 src, 1 valid, 2 busy_any
      int          idx;
      logic [63:0] val;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic [1:0]  wen;
      logic [1:0]  vld;
      logic [4:0]  rd0;
      logic [4:0]  rd1;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [4:0]  rs0;
      logic [4:0]  rs1;
      logic [63:0] s0;
      logic        v0;
      logic [63:0] s1;
      logic        v1;
   } vec_t;
   vec_t tbl[6];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic exp_src(input int k, input logic [63:0] v, input string n);
      q.push_back('{n, 0, k, v});
   endtask
   task automatic exp_vld(input int k, input logic v, input string n);
      q.push_back('{n, 1, k, {63'd0, v}});
   endtask
   task automatic exp_busy(input logic v, input string n);
      q.push_back('{n, 2, 0, {63'd0, v}});
   endtask
   task automatic exp_rd(input int k, input logic [63:0] s, input logic v, input string n);
      exp_src(k, s, {n, "_src"});
      exp_vld(k, v, {n, "_vld"});
   endtask

   task automatic idle();
      b.wb_wen = 0; b.wb_rd = '0; b.wb_data = '0;
      b.byp_wen = '0; b.byp_valid = '0; b.byp_rd = '0; b.byp_data = '0;
      b.lu_issue = '0; b.lu_issue_rd = '0;
      b.lu_done = '0; b.lu_done_rd = '0; b.lu_result = '0;
      b.flush = 0; b.rs = '0;
   endtask

   task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1);
      b.rs = {r1, r0};
   endtask

   // Compare everything queued for this cycle, then move past the next edge.
   task automatic chk();
      exp_t e;
      logic [63:0] act;
      @(negedge clk);
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            0:       act = b.src[e.idx*64 +: 64];
            1:       act = {63'd0, b.rs_valid[e.idx]};
            default: act = {63'd0, b.busy_any};
         endcase
         n_chk++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{2'b11, 2'b10, 5'd3, 5'd3, 64'hAA, 64'h55, 5'd3, 5'd5, 64'hAA, 1'b0, 64'h1234, 1'b1};
      tbl[1] = '{2'b10, 2'b10, 5'd3, 5'd3, 64'hAA, 64'h55, 5'd3, 5'd0, 64'h55, 1'b1, 64'h0, 1'b1};
      tbl[2] = '{2'b11, 2'b11, 5'd5, 5'd5, 64'h77, 64'h88, 5'd5, 5'd7, 64'h77, 1'b1, 64'hBEEF, 1'b1};
      tbl[3] = '{2'b01, 2'b01, 5'd0, 5'd0, 64'h99, 64'h0, 5'd0, 5'd5, 64'h0, 1'b1, 64'h1234, 1'b1};
      tbl[4] = '{2'b00, 2'b11, 5'd5, 5'd0, 64'h66, 64'h0, 5'd5, 5'd31, 64'h1234, 1'b1, 64'h0, 1'b1};
      tbl[5] = '{2'b10, 2'b00, 5'd0, 5'd7, 64'h0, 64'h33, 5'd7, 5'd5, 64'h33, 1'b0, 64'h1234, 1'b1};

      idle();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;

      set_rs(5'd5, 5'd0);
      exp_rd(0, 64'h0, 1'b0, "in_reset_p0");
      exp_rd(1, 64'h0, 1'b0, "in_reset_p1");
      exp_busy(1'b0, "in_reset_busy");
      chk();

      rst = 1;
      idle();
      b.wb_wen = 1; b.wb_rd = 5'd5; b.wb_data = 64'h1234;
      set_rs(5'd0, 5'd5);
      exp_rd(0, 64'h0, 1'b1, "x0_read");
      exp_rd(1, 64'h1234, 1'b1, "wb_fwd");
      exp_busy(1'b0, "idle_busy");
      chk();

      idle();
      set_rs(5'd5, 5'd0);
      exp_rd(0, 64'h1234, 1'b1, "wb_array");
      chk();

      idle();
      b.lu_issue = 2'b10; b.lu_issue_rd = {5'd7, 5'd0};
      set_rs(5'd7, 5'd0);
      exp_rd(0, 64'h0, 1'b1, "issue_cycle");
      chk();

      idle();
      set_rs(5'd7, 5'd0);
      exp_rd(0, 64'h0, 1'b0, "busy_stall");
      exp_busy(1'b1, "busy_set");
      chk();

      idle();
      b.lu_done = 2'b10; b.lu_done_rd = {5'd7, 5'd0}; b.lu_result = {64'hBEEF, 64'h0};
      set_rs(5'd7, 5'd0);
      exp_rd(0, 64'hBEEF, 1'b1, "lu_fwd");
      chk();

      idle();
      set_rs(5'd7, 5'd0);
      exp_rd(0, 64'hBEEF, 1'b1, "lu_array");
      exp_busy(1'b0, "busy_clr");
      chk();

      for (int t = 0; t < 6; t++) begin
         idle();
         b.byp_wen   = tbl[t].wen;
         b.byp_valid = tbl[t].vld;
         b.byp_rd    = {tbl[t].rd1, tbl[t].rd0};
         b.byp_data  = {tbl[t].d1, tbl[t].d0};
         set_rs(tbl[t].rs0, tbl[t].rs1);
         exp_rd(0, tbl[t].s0, tbl[t].v0, $sformatf("tbl%0d_p0", t));
         exp_rd(1, tbl[t].s1, tbl[t].v1, $sformatf("tbl%0d_p1", t));
         chk();
      end

      // Ownership: re-issue to the same rd while the old owner completes.
      idle();
      b.lu_issue = 2'b01; b.lu_issue_rd = {5'd0, 5'd9};
      chk();
      idle();
      b.lu_done = 2'b01; b.lu_done_rd = {5'd0, 5'd9}; b.lu_result = {64'h0, 64'hD0};
      b.lu_issue = 2'b10; b.lu_issue_rd = {5'd9, 5'd0};
      set_rs(5'd9, 5'd0);
      exp_rd(0, 64'hD0, 1'b1, "own0_done_fwd");
      chk();
      idle();
      set_rs(5'd9, 5'd0);
      exp_vld(0, 1'b0, "reissue_busy_vld");
      exp_busy(1'b1, "reissue_busy");
      chk();
      idle();
      b.lu_done = 2'b01; b.lu_done_rd = {5'd0, 5'd9}; b.lu_result = {64'h0, 64'hD1};
      set_rs(5'd9, 5'd0);
      exp_rd(0, 64'h0, 1'b0, "stale_done");
      chk();
      idle();
      set_rs(5'd9, 5'd0);
      exp_vld(0, 1'b0, "stale_keeps_busy");
      exp_busy(1'b1, "stale_busy_any");
      chk();
      idle();
      b.lu_done = 2'b10; b.lu_done_rd = {5'd9, 5'd0}; b.lu_result = {64'hD2, 64'h0};
      set_rs(5'd9, 5'd0);
      exp_rd(0, 64'hD2, 1'b1, "own1_done_fwd");
      chk();
      idle();
      set_rs(5'd9, 5'd0);
      exp_rd(0, 64'hD2, 1'b1, "own1_array");
      exp_busy(1'b0, "own1_clr");
      chk();

      // Flush squashes pending ops and a same-cycle issue.
      idle();
      b.wb_wen = 1; b.wb_rd = 5'd4; b.wb_data = 64'h44;
      chk();
      idle();
      b.wb_wen = 1; b.wb_rd = 5'd6; b.wb_data = 64'h66;
      chk();
      idle();
      b.lu_issue = 2'b11; b.lu_issue_rd = {5'd6, 5'd4};
      set_rs(5'd4, 5'd0);
      exp_rd(0, 64'h44, 1'b1, "pre_issue");
      chk();
      idle();
      b.flush = 1;
      b.lu_issue = 2'b01; b.lu_issue_rd = {5'd0, 5'd10};
      set_rs(5'd4, 5'd6);
      exp_vld(0, 1'b0, "pre_flush_v4");
      exp_vld(1, 1'b0, "pre_flush_v6");
      exp_busy(1'b1, "pre_flush_busy");
      chk();
      idle();
      set_rs(5'd4, 5'd6);
      exp_rd(0, 64'h44, 1'b1, "post_flush_x4");
      exp_rd(1, 64'h66, 1'b1, "post_flush_x6");
      exp_busy(1'b0, "post_flush_busy");
      chk();
      idle();
      set_rs(5'd10, 5'd0);
      exp_vld(0, 1'b1, "flush_over_issue");
      chk();

      // WAW priority: WB over LU, lower LU index over higher.
      idle();
      b.wb_wen = 1; b.wb_rd = 5'd8; b.wb_data = 64'h11;
      b.lu_done = 2'b01; b.lu_done_rd = {5'd0, 5'd8}; b.lu_result = {64'h0, 64'h22};
      set_rs(5'd8, 5'd0);
      exp_rd(0, 64'h11, 1'b1, "waw_fwd");
      chk();
      idle();
      b.lu_done = 2'b11; b.lu_done_rd = {5'd11, 5'd11}; b.lu_result = {64'hB0, 64'hA0};
      set_rs(5'd8, 5'd11);
      exp_rd(0, 64'h11, 1'b1, "waw_wb_wins");
      exp_rd(1, 64'h0, 1'b1, "lu_unowned_nofwd");
      chk();
      idle();
      set_rs(5'd11, 5'd0);
      exp_rd(0, 64'hA0, 1'b1, "lu_low_wins");
      chk();

      // Reset in the middle of activity.
      idle();
      b.lu_issue = 2'b01; b.lu_issue_rd = {5'd0, 5'd12};
      chk();
      idle();
      set_rs(5'd12, 5'd0);
      exp_busy(1'b1, "pre_reset_busy");
      chk();
      idle();
      rst = 0;
      set_rs(5'd5, 5'd0);
      exp_rd(0, 64'h0, 1'b0, "mid_reset");
      exp_busy(1'b0, "mid_reset_busy");
      chk();
      rst = 1;
      idle();
      set_rs(5'd5, 5'd8);
      exp_rd(0, 64'h0, 1'b1, "post_reset_x5");
      exp_rd(1, 64'h0, 1'b1, "post_reset_x8");
      exp_busy(1'b0, "post_reset_busy");
      chk();
      idle();
      set_rs(5'd12, 5'd7);
      exp_rd(0, 64'h0, 1'b1, "post_reset_x12");
      exp_rd(1, 64'h0, 1'b1, "post_reset_x7");
      chk();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_220066_regfile_sb.md
Name: ysyx_220066_regfile_sb

Overview:
Parametrised integer register file with an integrated scoreboard and a multi-source operand bypass network, serving the decode/issue stage.
- Generalises the current fixed 2-read, single-multiplier/divider register file to NRD read ports, NBYP pipeline bypass sources and NLU long-latency units.
- Tracks in-flight long-latency destinations with per-register busy bits and per-register owner tags.
- Returns each operand together with a valid flag that tells issue whether it may proceed.

Parameters:
XLEN, 64, data width of each register.
NREG, 32, number of architectural registers; register 0 is hardwired to zero.
AW, 5, register address width; must satisfy 2^AW >= NREG.
NRD, 2, number of read ports.
NBYP, 2, number of pipeline bypass sources; index 0 is the youngest stage.
NLU, 2, number of long-latency units (mul, div, ...).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-low reset.
wb_wen  in  1  writeback write enable.
wb_rd  in  AW  writeback destination register.
wb_data  in  XLEN  writeback data.
byp_wen  in  NBYP  bypass source i holds a destination-register write.
byp_valid  in  NBYP  bypass source i data is ready; 0 means the result is still pending (e.g. a load).
byp_rd  in  NBYP*AW  packed bypass destinations.
byp_data  in  NBYP*XLEN  packed bypass data.
lu_issue  in  NLU  unit j accepts an op this cycle.
lu_issue_rd  in  NLU*AW  destination of the issued op.
lu_done  in  NLU  unit j presents its result this cycle.
lu_done_rd  in  NLU*AW  result destination.
lu_result  in  NLU*XLEN  result data.
flush  in  1  pipeline flush; squashes all pending long-latency ops.
rs  in  NRD*AW  packed read addresses.
src  out  NRD*XLEN  packed operand data.
rs_valid  out  NRD  operand k is usable this cycle.
busy_any  out  1  OR of all busy bits; used by fence/CSR drain logic.

Behaviour:
Reset (rst==0 at a rising edge):
- All registers are set to 0; all busy bits and owner tags are cleared.
- While rst==0, src is driven to 0, rs_valid to 0 and busy_any to 0.

Writes (one-cycle latency into the array):
- The WB port writes when wb_wen is set and wb_rd!=0.
- Each LU port j writes lu_result[j] when lu_done[j] is set and lu_done_rd[j]!=0.
- Same-register conflict in one cycle: WB wins over LU, because WB is the younger instruction (WAW). Among LU ports, the lowest j wins.

Scoreboard:
- An lu_issue[j] with rd!=0 sets busy[rd] and owner[rd]=j at the next edge.
- An lu_done[j] clears busy[rd] only if owner[rd]==j.
- If an issue and a done hit the same register in the same cycle, the issue wins: busy stays 1 and the owner becomes the new unit.
- flush clears every busy bit at the next edge and overrides any same-cycle issue. An lu_done arriving after a flush still writes the array; the pipeline guarantees that squashed units are killed.

Read (combinational, independent per port k). The first matching rule applies:
1. rs==0: src=0, valid=1.
2. Lowest-index bypass i with byp_wen[i] and byp_rd[i]==rs: src=byp_data[i], valid=byp_valid[i].
3. busy[rs] and lu_done[owner] with a matching rd: src=lu_result[owner], valid=1.
4. busy[rs]: src=0, valid=0.
5. wb_wen and wb_rd==rs: src=wb_data, valid=1.
6. Otherwise: src=array[rs], valid=1.

Out-of-range addresses (rs >= NREG) read 0 with valid=1; writes to them are ignored.

Optional Feature:
YSYX_220066_REGDUMP_EN
- Defined: adds two ports, dbg_addr (in, AW) and dbg_data (out, XLEN). dbg_data is a combinational read of the array with no bypass and 0 for address 0, used by difftest register comparison.
- Undefined: those ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then write x5=0x1234 via WB; the next cycle rs0=5 -> src=0x1234, valid=1. rs0=0 at any time -> src=0, valid=1.
- lu_issue[1] with rd=7; the next cycle rs0=7 -> valid=0. Then lu_done[1] with rd=7, result 0xBEEF -> same cycle src=0xBEEF, valid=1; the next cycle busy_any=0 and the array reads 0xBEEF.
- byp0 (rd=3, valid=0) and byp1 (rd=3, data=0x55, valid=1) together -> rs=3 gives valid=0 (youngest wins). Drop byp0 -> src=0x55, valid=1.
- lu_issue[0] rd=9, then in one cycle lu_done[0] rd=9 plus lu_issue[1] rd=9 -> busy stays 1 with owner=1. A later lu_done[0] rd=9 leaves it busy; lu_done[1] clears it.
- Issue units 0 and 1 to rd=4 and rd=6, then assert flush -> busy_any=0 the next cycle, and rs=4 and rs=6 are valid with their old array data.
- Same-cycle WB rd=8=0x11 and lu_done[0] rd=8=0x22 -> the array holds 0x11. Reset asserted mid-operation -> all registers read 0 and busy_any=0 after release.
